// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes, FSM
// states and the counter-width helper.
package univ_shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Wide enough to hold burst lengths 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg. master = driving side, slave = register.
interface univ_shift_reg_if
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4
);
  localparam int CNT_W = cnt_width(WIDTH);

  // Handshake: start is a level request sampled only while idle; there is no
  // ready. busy is high throughout an accepted burst and done pulses for one
  // cycle once it completes, after which a new start is accepted at once.
  logic             en;
  logic [1:0]       mode;
  logic             rotate;
  logic             serial_in_msb;
  logic             serial_in_lsb;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] burst_len;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out_msb;
  logic             serial_out_lsb;
  logic             busy;
  logic             done;
  logic             fsm_state;

  modport master (
    output en, mode, rotate, serial_in_msb, serial_in_lsb, parallel_in,
           start, burst_len,
    input  parallel_out, serial_out_msb, serial_out_lsb, busy, done, fsm_state
  );

  modport slave (
    input  en, mode, rotate, serial_in_msb, serial_in_lsb, parallel_in,
           start, burst_len,
    output parallel_out, serial_out_msb, serial_out_lsb, busy, done, fsm_state
  );

endinterface

// File: rtl/univ_shift_reg_datapath.sv
// Combinational next-value mux: hold, shift right/left with fill selection, load.
module shift_datapath
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             serial_in_msb,
  input  logic             serial_in_lsb,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] q_next
);

  logic fill_r;
  logic fill_l;

  assign fill_r = rotate ? q[0]       : serial_in_msb;
  assign fill_l = rotate ? q[WIDTH-1] : serial_in_lsb;

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHR:  q_next = {fill_r, q[WIDTH-1:1]};
      MODE_SHL:  q_next = {q[WIDTH-2:0], fill_l};
      MODE_LOAD: q_next = parallel_in;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operations and an autonomous
// N-position burst engine reporting busy/done.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            reset_n,
  univ_shift_reg_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_SHIFT = ST_SHIFT;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             dir_left;
  logic             rot_lat;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             done_r;
  logic [1:0]       dp_mode;
  logic             dp_rotate;
  logic             start_shift;

  // During a burst the datapath follows the latched direction/rotate, not the bus.
  assign dp_mode     = (state == S_SHIFT) ? (dir_left ? MODE_SHL : MODE_SHR) : bus.mode;
  assign dp_rotate   = (state == S_SHIFT) ? rot_lat : bus.rotate;
  assign start_shift = bus.start && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);

  shift_datapath #(.WIDTH(WIDTH)) u_dp (
    .q             (q),
    .mode          (dp_mode),
    .rotate        (dp_rotate),
    .serial_in_msb (bus.serial_in_msb),
    .serial_in_lsb (bus.serial_in_lsb),
    .parallel_in   (bus.parallel_in),
    .q_next        (q_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      dir_left <= 1'b0;
      rot_lat  <= 1'b0;
      q        <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_shift) begin
            // Zero-length burst completes immediately without touching data.
            if (bus.burst_len != '0) begin
              state    <= S_SHIFT;
              cnt      <= bus.burst_len;
              dir_left <= (bus.mode == MODE_SHL);
              rot_lat  <= bus.rotate;
            end else begin
              done_r <= 1'b1;
            end
          end else if (bus.en) begin
            q <= q_next;
          end
        end
        S_SHIFT: begin
          if (bus.en) begin
            q   <= q_next;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state  <= S_IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.parallel_out   = q;
  assign bus.serial_out_msb = q[WIDTH-1];
  assign bus.serial_out_lsb = q[0];
  assign bus.busy           = (state == S_SHIFT);
  assign bus.done           = done_r;
  assign bus.fsm_state      = state[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=4): vector table through a
// scoreboard queue, plus reset and asynchronous mid-burst reset sequences.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int W = 4;

  typedef struct {
    logic         en;
    logic [1:0]   mode;
    logic         rot;
    logic         sim;
    logic         sil;
    logic [W-1:0] pin;
    logic         start;
    logic [2:0]   blen;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } vec_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  logic [7:0] exp_q[$];
  vec_t       vecs[$];

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pack_exp(input logic [W-1:0] q, input logic b, input logic d);
    return {q, q[W-1], q[0], b, d};
  endfunction

  function automatic logic [7:0] observe();
    return {bus.parallel_out, bus.serial_out_msb, bus.serial_out_lsb, bus.busy, bus.done};
  endfunction

  function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic rot,
                              input logic sim, input logic sil, input logic [W-1:0] pin,
                              input logic start, input logic [2:0] blen,
                              input logic [W-1:0] q, input logic b, input logic d);
    vec_t v;
    v.en = en; v.mode = mode; v.rot = rot; v.sim = sim; v.sil = sil; v.pin = pin;
    v.start = start; v.blen = blen; v.q = q; v.busy = b; v.done = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got q=%b so=%b%b busy=%b done=%b, want q=%b so=%b%b busy=%b done=%b",
               name, got[7:4], got[3], got[2], got[1], got[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver: inputs change 1 ns after the rising edge
  task automatic drive(input vec_t v);
    bus.en            = v.en;
    bus.mode          = v.mode;
    bus.rotate        = v.rot;
    bus.serial_in_msb = v.sim;
    bus.serial_in_lsb = v.sil;
    bus.parallel_in   = v.pin;
    bus.start         = v.start;
    bus.burst_len     = v.blen;
  endtask

  // scoreboard: expectation queued at drive time, popped once the edge has produced it
  task automatic apply(input vec_t v, input string name);
    logic [7:0] e;
    drive(v);
    exp_q.push_back(pack_exp(v.q, v.busy, v.done));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %b want an entry", name, observe());
    end else begin
      e = exp_q.pop_front();
      check(name, observe(), e);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(mk(0, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0000, 0, 0));
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", observe(), pack_exp(4'b0000, 0, 0));
    reset_n = 1'b1;

    //           en mode       rot sim sil pin     st blen  q       b  d
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 0, 4'b1011, 0, 3'd0, 4'b1011, 0, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b1011, 0, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0, 4'b0000, 0, 3'd0, 4'b0101, 0, 0));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 1, 4'b0000, 0, 3'd0, 4'b1011, 0, 0));
    vecs.push_back(mk(1, MODE_SHR,  1, 0, 0, 4'b0000, 0, 3'd0, 4'b1101, 0, 0));
    // rotate-left burst of 3 from 1100
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 0, 4'b1100, 0, 3'd0, 4'b1100, 0, 0));
    vecs.push_back(mk(1, MODE_SHL,  1, 0, 0, 4'b0000, 1, 3'd3, 4'b1100, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b1001, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0011, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0110, 0, 1));
    vecs.push_back(mk(0, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0110, 0, 0));
    // stalled right burst of 2 from 1000; load/start ignored while busy
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 0, 4'b1000, 0, 3'd0, 4'b1000, 0, 0));
    vecs.push_back(mk(1, MODE_SHR,  0, 0, 0, 4'b0000, 1, 3'd2, 4'b1000, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0100, 1, 0));
    vecs.push_back(mk(0, MODE_LOAD, 0, 0, 0, 4'b1111, 1, 3'd3, 4'b0100, 1, 0));
    vecs.push_back(mk(0, MODE_LOAD, 0, 0, 0, 4'b1111, 0, 3'd3, 4'b0100, 1, 0));
    vecs.push_back(mk(1, MODE_LOAD, 1, 0, 0, 4'b1111, 1, 3'd3, 4'b0010, 0, 1));
    vecs.push_back(mk(0, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0010, 0, 0));
    // zero-length burst and starts in non-shift modes
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 1, 4'b0000, 1, 3'd0, 4'b0010, 0, 1));
    vecs.push_back(mk(0, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0010, 0, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 1, 3'd3, 4'b0010, 0, 0));
    vecs.push_back(mk(1, MODE_LOAD, 0, 0, 0, 4'b0101, 1, 3'd3, 4'b0101, 0, 0));
    // back-to-back single-shift bursts
    vecs.push_back(mk(1, MODE_SHR,  1, 0, 0, 4'b0000, 1, 3'd1, 4'b0101, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b1010, 0, 1));
    vecs.push_back(mk(1, MODE_SHL,  0, 0, 0, 4'b0000, 1, 3'd1, 4'b1010, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 1, 4'b0000, 0, 3'd0, 4'b0101, 0, 1));
    vecs.push_back(mk(0, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0101, 0, 0));
    // rotate burst of WIDTH returns the original value
    vecs.push_back(mk(1, MODE_SHL,  1, 0, 0, 4'b0000, 1, 3'd4, 4'b0101, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b1010, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0101, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b1010, 1, 0));
    vecs.push_back(mk(1, MODE_HOLD, 0, 0, 0, 4'b0000, 0, 3'd0, 4'b0101, 0, 1));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // async reset in the middle of a 4-shift burst (fill 1 from msb)
    apply(mk(1, MODE_SHR, 0, 1, 0, 4'b0000, 1, 3'd4, 4'b0101, 1, 0), "mid_accept");
    apply(mk(1, MODE_HOLD, 0, 1, 0, 4'b0000, 0, 3'd0, 4'b1010, 1, 0), "mid_shift1");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", observe(), pack_exp(4'b0000, 0, 0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("post_reset%0d", k), observe(), pack_exp(4'b0000, 0, 0));
      @(posedge clk);
      #1;
    end

    // register still functional after recovery
    apply(mk(1, MODE_SHL, 0, 0, 1, 4'b0000, 0, 3'd0, 4'b0001, 0, 0), "recover_shl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register; next generation of the team's 4-bit parallel-in/parallel-out register.
- Per-cycle operations: hold, shift left, shift right, parallel load, with logical-shift or rotate fill.
- Adds an autonomous burst engine: shifts N positions on its own, with busy/done status.
- Used as a configurable data-staging element between parallel buses and bit-serial links.

Parameters:
- WIDTH, 4, register width in bits (legal range 2..64).
- CNT_W, derived as $clog2(WIDTH+1), width of burst_len and of the internal counter (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  operation enable; 0 = hold, and stalls an active burst.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- rotate  input  1  1 = shifted-out bit refills the vacated end; 0 = fill from the serial input.
- serial_in_msb  input  1  fill bit for shift right.
- serial_in_lsb  input  1  fill bit for shift left.
- parallel_in  input  WIDTH  load data.
- start  input  1  burst request, sampled in IDLE only.
- burst_len  input  CNT_W  number of shift positions for the burst.
- parallel_out  output  WIDTH  register contents.
- serial_out_msb  output  1  parallel_out[WIDTH-1], combinational from the register.
- serial_out_lsb  output  1  parallel_out[0], combinational from the register.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous, reset_n=0): parallel_out=0, busy=0, done=0, counter=0, state=IDLE. Takes effect immediately, including mid-burst; the burst is abandoned and no done pulse is produced.
- States: IDLE, SHIFT. done is registered and defaults to 0 every cycle.
- Shift definitions:
  - Right: q <= {fill, q[W-1:1]}, where fill = rotate ? q[0] : serial_in_msb.
  - Left: q <= {q[W-2:0], fill}, where fill = rotate ? q[W-1] : serial_in_lsb.
- IDLE, start=0: if en=1, the mode operation is applied at the clock edge (1-cycle latency). Load: q <= parallel_in. en=0: hold.
- IDLE, start=1: start takes precedence over the single-step operation. en is ignored on the acceptance cycle.
  - mode=01 or 10, burst_len>0: latch direction and rotate, counter <= burst_len, go to SHIFT. No shift occurs on the acceptance edge.
  - mode=01 or 10, burst_len=0: stay IDLE, no data change, done=1 next cycle.
  - mode=00 or 11: start is ignored and treated as a plain single-step cycle (hold or load if en=1).
- SHIFT: on each edge with en=1, perform one shift using the latched direction and rotate, and decrement the counter. When the counter is 1 at that edge: go to IDLE with done=1.
  - en=0 stalls the burst: no shift, counter unchanged, busy stays 1.
  - serial_in_* is sampled live each shifting cycle.
  - start, mode, rotate and parallel_in are ignored while in SHIFT.
- Timing for an N-shift burst with en held high: busy=1 for exactly N cycles starting the cycle after acceptance; done pulses in the cycle after the last shift.
- Back-to-back: a start in the cycle where done=1 (state IDLE) is accepted.
- burst_len>WIDTH is legal. With rotate=1, burst_len=WIDTH returns the original value.

Decomposition:
- Package univ_shift_pkg holds:
  - mode encodings: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD;
  - state enum: ST_IDLE, ST_SHIFT;
  - a function computing CNT_W from WIDTH.
- One natural sub-module, shift_datapath: the combinational next-value mux (hold/shr/shl/load with fill selection). The top module holds the registers, FSM and counter.

Test Plan:
- Reset then load (WIDTH=4): reset_n=0 for 2 cycles, release; en=1, mode=11, parallel_in=1011 -> parallel_out=1011 after one edge; mode=00 -> stays 1011.
- Single shifts: from 1011, mode=01, rotate=0, serial_in_msb=0 -> 0101; mode=10, rotate=0, serial_in_lsb=1 -> 1011; mode=01, rotate=1 -> 1101.
- Rotate burst: load 1100; start=1, mode=10, rotate=1, burst_len=3 -> busy=1 for 3 cycles, parallel_out steps 1001, 0011, 0110; done=1 one cycle; final 0110.
- Stall and ignore: burst right, burst_len=2, on 1000 with serial_in_msb=0; hold en=0 for 2 cycles mid-burst and pulse start and mode=11 during busy -> value frozen during the stall, load ignored, final 0010, busy=1 for 4 cycles total.
- Edge starts: start with burst_len=0 -> no change, done pulse next cycle, busy stays 0; start with mode=00 -> ignored, no busy, no done.
- Reset mid-burst: assert reset_n=0 asynchronously (between edges) during a burst of 4 -> parallel_out=0, busy=0, done=0 immediately; no done pulse after release.
